// File: rtl/pic_8259_lite.sv
// pic_8259_lite: single, non-cascaded 8259A-style interrupt controller.
// It is programmed through the shared 40-bit IO request stream at BASE_ADDR and BASE_ADDR+1.
// It presents one interrupt vector at a time to the CPU on a valid/ready stream.
//
// Handshake semantics: a transfer happens on a cycle where valid & ready are both high.
// A producer holds valid and data stable until that cycle. Ready may depend on internal state.
// In this block, io_req_s_tready is simply !io_rd_m_tvalid.
module pic_8259_lite #(
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_req_s_tvalid,
  output logic        io_req_s_tready,
  input  logic [39:0] io_req_s_tdata,
  output logic        io_rd_m_tvalid,
  input  logic        io_rd_m_tready,
  output logic [15:0] io_rd_m_tdata,
  input  logic [7:0]  irq_in,
  output logic        int_m_tvalid,
  input  logic        int_m_tready,
  output logic [7:0]  int_m_tdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_ICW2  = 2'd1,
    ST_ICW3  = 2'd2,
    ST_ICW4  = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  irr;
  logic [7:0]  isr;
  logic [7:0]  imr;
  logic [7:0]  irq_prev;
  logic [4:0]  vec_base;
  logic        aeoi;
  logic        rd_sel;   // 0: IRR, 1: ISR
  logic        sngl;
  logic        ic4;

  // Request field decode
  logic        req_fire;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        hit;
  logic        p;
  logic [7:0]  d;
  logic        unused_req;

  assign io_req_s_tready = !io_rd_m_tvalid;
  assign req_fire   = io_req_s_tvalid & io_req_s_tready;
  assign req_wr     = io_req_s_tdata[32];
  assign req_addr   = io_req_s_tdata[31:16];
  assign req_data   = io_req_s_tdata[15:0];
  assign hit        = (req_addr[15:1] == BASE_ADDR[15:1]);
  assign p          = req_addr[0];
  assign d          = req_data[7:0];
  assign unused_req = ^{io_req_s_tdata[39:33], req_data[15:8]};
  assign dbg_state  = state;

  // Write classification
  logic wr_fire, rd_fire, icw1, icw_data, ocw1, ocw2, ocw3, ns_eoi, sp_eoi;
  assign wr_fire  = req_fire & req_wr & hit;
  assign rd_fire  = req_fire & !req_wr & hit;
  assign icw1     = wr_fire & !p & d[4];
  assign icw_data = wr_fire & p & (state != ST_READY);
  assign ocw1     = wr_fire & p & (state == ST_READY);
  assign ocw2     = wr_fire & !p & (d[4:3] == 2'b00) & (state == ST_READY);
  assign ocw3     = wr_fire & !p & (d[4:3] == 2'b01) & (state == ST_READY);
  assign ns_eoi   = ocw2 & (d[7:5] == 3'b001);
  assign sp_eoi   = ocw2 & (d[7:5] == 3'b011);

  logic       ack;
  logic [2:0] ack_idx;
  assign ack     = int_m_tvalid & int_m_tready;
  assign ack_idx = int_m_tdata[2:0];

  // Priority resolution: lowest unmasked request, blocked by any in-service level at or above it
  logic [7:0] cand;
  logic [2:0] cand_idx;
  logic       cand_any;
  logic       blocked;
  logic [2:0] isr_low;
  logic       isr_any;
  logic       arb_fire;
  always_comb begin
    cand     = irr & ~imr;
    cand_idx = 3'd0;
    cand_any = 1'b0;
    isr_low  = 3'd0;
    isr_any  = 1'b0;
    blocked  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) begin
        cand_idx = 3'(i);
        cand_any = 1'b1;
      end
      if (isr[i]) begin
        isr_low = 3'(i);
        isr_any = 1'b1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (isr[i] && (3'(i) <= cand_idx)) blocked = 1'b1;
    end
    arb_fire = (state == ST_READY) & !int_m_tvalid & cand_any & !blocked;
  end

  // Next IRR/ISR: edge set beats ack clear; EOI before ack set; ICW1 overrides everything
  logic [7:0] irq_edge;
  logic [7:0] irr_nxt;
  logic [7:0] isr_nxt;
  always_comb begin
    irq_edge = irq_in & ~irq_prev;
    irr_nxt  = irr;
    if (ack) irr_nxt[ack_idx] = 1'b0;
    irr_nxt  = irr_nxt | irq_edge;
    if (icw1) irr_nxt = 8'h00;
    isr_nxt = isr;
    if (ns_eoi && isr_any) isr_nxt[isr_low] = 1'b0;
    if (sp_eoi) isr_nxt[d[2:0]] = 1'b0;
    if (ack && !aeoi) isr_nxt[ack_idx] = 1'b1;
    if (icw1) isr_nxt = 8'h00;
  end

  // Register state, init FSM, read response and vector output
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_READY;
      irr            <= 8'h00;
      isr            <= 8'h00;
      imr            <= 8'hFF;
      irq_prev       <= 8'h00;
      vec_base       <= 5'h01;
      aeoi           <= 1'b0;
      rd_sel         <= 1'b0;
      sngl           <= 1'b0;
      ic4            <= 1'b0;
      io_rd_m_tvalid <= 1'b0;
      io_rd_m_tdata  <= 16'h0000;
      int_m_tvalid   <= 1'b0;
      int_m_tdata    <= 8'h00;
    end else begin
      irr      <= irr_nxt;
      isr      <= isr_nxt;
      irq_prev <= icw1 ? 8'h00 : irq_in;

      if (icw1) begin
        imr    <= 8'h00;
        aeoi   <= 1'b0;
        rd_sel <= 1'b0;
        sngl   <= d[1];
        ic4    <= d[0];
        state  <= ST_ICW2;
      end else if (icw_data) begin
        case (state)
          ST_ICW2: begin
            vec_base <= d[7:3];
            if (!sngl)   state <= ST_ICW3;
            else if (ic4) state <= ST_ICW4;
            else          state <= ST_READY;
          end
          ST_ICW3: state <= ic4 ? ST_ICW4 : ST_READY;
          ST_ICW4: begin
            aeoi  <= d[1];
            state <= ST_READY;
          end
          default: state <= ST_READY;
        endcase
      end else begin
        if (ocw1) imr <= d;
        if (ocw3 && d[1]) rd_sel <= d[0];
      end

      if (rd_fire) begin
        io_rd_m_tvalid <= 1'b1;
        io_rd_m_tdata  <= {8'h00, p ? imr : (rd_sel ? isr : irr)};
      end else if (io_rd_m_tvalid && io_rd_m_tready) begin
        io_rd_m_tvalid <= 1'b0;
      end

      if (icw1 || ack) begin
        int_m_tvalid <= 1'b0;
      end else if (arb_fire) begin
        int_m_tvalid <= 1'b1;
        int_m_tdata  <= {vec_base, cand_idx};
      end
    end
  end

endmodule

// File: tb/tb_pic_8259_lite.sv
// tb_pic_8259_lite: programs the controller, raises requests and checks the presented
// vectors and register reads against expected values queued at stimulus time.
module tb_pic_8259_lite;

  logic        clk = 1'b0;
  logic        resetn;
  logic        io_req_s_tvalid;
  logic        io_req_s_tready;
  logic [39:0] io_req_s_tdata;
  logic        io_rd_m_tvalid;
  logic        io_rd_m_tready;
  logic [15:0] io_rd_m_tdata;
  logic [7:0]  irq_in;
  logic        int_m_tvalid;
  logic        int_m_tready;
  logic [7:0]  int_m_tdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] rd_q[$];

  pic_8259_lite #(.BASE_ADDR(16'h0020)) dut (
    .clk(clk),
    .resetn(resetn),
    .io_req_s_tvalid(io_req_s_tvalid),
    .io_req_s_tready(io_req_s_tready),
    .io_req_s_tdata(io_req_s_tdata),
    .io_rd_m_tvalid(io_rd_m_tvalid),
    .io_rd_m_tready(io_rd_m_tready),
    .io_rd_m_tdata(io_rd_m_tdata),
    .irq_in(irq_in),
    .int_m_tvalid(int_m_tvalid),
    .int_m_tready(int_m_tready),
    .int_m_tdata(int_m_tdata),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic p, input logic [7:0] d);
    @(negedge clk);
    io_req_s_tvalid = 1'b1;
    io_req_s_tdata  = {7'd0, 1'b1, 15'h0010, p, 8'h00, d};
    for (int k = 0; k < 20 && !io_req_s_tready; k++) @(negedge clk);
    if (!io_req_s_tready) check_eq("wr_tmo", 16'(io_req_s_tready), 16'd1);
    @(posedge clk);
    #1;
    io_req_s_tvalid = 1'b0;
  endtask

  task automatic io_read(input logic p, input logic [15:0] exp, input int hold);
    logic [15:0] got;
    rd_q.push_back(exp);
    @(negedge clk);
    io_req_s_tvalid = 1'b1;
    io_req_s_tdata  = {7'd0, 1'b0, 15'h0010, p, 16'h0000};
    @(posedge clk);
    #1;
    io_req_s_tvalid = 1'b0;
    @(negedge clk);
    check_eq("rd_lat", 16'(io_rd_m_tvalid), 16'd1);
    for (int k = 0; k < 10 && !io_rd_m_tvalid; k++) @(negedge clk);
    if (!io_rd_m_tvalid) begin
      void'(rd_q.pop_front());
      return;
    end
    got = io_rd_m_tdata;
    check_eq("rd_data", got, rd_q.pop_front());
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("rd_hold_valid", 16'(io_rd_m_tvalid), 16'd1);
      check_eq("rd_backpressure", 16'(io_req_s_tready), 16'd0);
      check_eq("rd_stable", io_rd_m_tdata, got);
    end
    io_rd_m_tready = 1'b1;
    @(negedge clk);
    io_rd_m_tready = 1'b0;
    check_eq("rd_drop", 16'(io_rd_m_tvalid), 16'd0);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    @(negedge clk);
    irq_in = m;
    @(negedge clk);
    irq_in = 8'h00;
  endtask

  task automatic expect_vec(input bit do_ack);
    for (int k = 0; k < 20 && !int_m_tvalid; k++) @(negedge clk);
    if (!int_m_tvalid) begin
      check_eq("vec_tmo", 16'(int_m_tvalid), 16'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("vec_unexpected", 16'(int_m_tdata), 16'hFFFF);
      return;
    end
    check_eq("vec", 16'(int_m_tdata), 16'(exp_q.pop_front()));
    if (do_ack) begin
      int_m_tready = 1'b1;
      @(negedge clk);
      int_m_tready = 1'b0;
      check_eq("ack_drop", 16'(int_m_tvalid), 16'd0);
    end
  endtask

  task automatic expect_idle(input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (int_m_tvalid) seen = 1'b1;
    end
    check_eq("idle", 16'(seen), 16'd0);
  endtask

  initial begin
    // Reset
    resetn          = 1'b0;
    io_req_s_tvalid = 1'b0;
    io_req_s_tdata  = 40'd0;
    io_rd_m_tready  = 1'b0;
    irq_in          = 8'h00;
    int_m_tready    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_int_valid", 16'(int_m_tvalid), 16'd0);
    check_eq("rst_int_data", 16'(int_m_tdata), 16'd0);
    check_eq("rst_rd_valid", 16'(io_rd_m_tvalid), 16'd0);
    check_eq("rst_rd_data", io_rd_m_tdata, 16'd0);
    check_eq("rst_req_ready", 16'(io_req_s_tready), 16'd1);
    check_eq("rst_state", 16'(dbg_state), 16'd0);
    resetn = 1'b1;
    io_read(1'b1, 16'h00FF, 0);
    io_read(1'b0, 16'h0000, 0);
    // Masked lines still latch into IRR
    pulse_irq(8'h80);
    io_read(1'b0, 16'h0080, 0);

    // 1: init and first vector latency
    io_write(1'b0, 8'h13);
    check_eq("st_icw2", 16'(dbg_state), 16'd1);
    io_write(1'b1, 8'h08);
    check_eq("st_icw4", 16'(dbg_state), 16'd3);
    io_write(1'b1, 8'h01);
    check_eq("st_ready", 16'(dbg_state), 16'd0);
    io_write(1'b1, 8'hFE);
    io_read(1'b0, 16'h0000, 0);
    @(negedge clk);
    irq_in = 8'h01;
    exp_q.push_back(8'h08);
    @(negedge clk);
    check_eq("lat_t1", 16'(int_m_tvalid), 16'd0);
    irq_in = 8'h00;
    @(negedge clk);
    check_eq("lat_t2", 16'(int_m_tvalid), 16'd1);
    expect_vec(1'b1);

    // 2: in-service IR0 blocks itself until EOI
    exp_q.push_back(8'h08);
    pulse_irq(8'h01);
    expect_idle(6);
    io_write(1'b0, 8'h20);
    expect_vec(1'b1);
    io_write(1'b0, 8'h20);

    // 3: simultaneous IR3 and IR1
    io_write(1'b1, 8'h00);
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h0B);
    pulse_irq(8'h0A);
    expect_vec(1'b1);
    expect_idle(4);
    io_write(1'b0, 8'h20);
    expect_vec(1'b1);

    // 4: IR3 in service; IR5 waits, IR2 nests
    pulse_irq(8'h20);
    expect_idle(6);
    exp_q.push_back(8'h0A);
    pulse_irq(8'h04);
    expect_vec(1'b1);
    io_write(1'b0, 8'h63);

    // 5: register reads with back-pressure
    io_write(1'b0, 8'h0B);
    io_read(1'b0, 16'h0004, 3);
    io_write(1'b0, 8'h0A);
    io_read(1'b0, 16'h0020, 0);
    io_read(1'b1, 16'h0000, 0);
    exp_q.push_back(8'h0D);
    io_write(1'b0, 8'h20);
    expect_vec(1'b1);
    io_write(1'b0, 8'h20);
    io_write(1'b0, 8'h0B);
    io_read(1'b0, 16'h0000, 0);

    // 6: full init with ICW3, auto-EOI, then reset with a pending vector
    io_write(1'b0, 8'h11);
    check_eq("st6_icw2", 16'(dbg_state), 16'd1);
    io_write(1'b1, 8'h08);
    check_eq("st6_icw3", 16'(dbg_state), 16'd2);
    io_write(1'b1, 8'h00);
    check_eq("st6_icw4", 16'(dbg_state), 16'd3);
    io_write(1'b1, 8'h03);
    check_eq("st6_ready", 16'(dbg_state), 16'd0);
    io_write(1'b1, 8'hFE);
    exp_q.push_back(8'h08);
    pulse_irq(8'h01);
    expect_vec(1'b1);
    io_write(1'b0, 8'h0B);
    io_read(1'b0, 16'h0000, 0);
    exp_q.push_back(8'h08);
    pulse_irq(8'h01);
    expect_vec(1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_valid", 16'(int_m_tvalid), 16'd0);
    resetn = 1'b1;
    io_read(1'b1, 16'h00FF, 0);
    check_eq("rst_mid_state", 16'(dbg_state), 16'd0);

    check_eq("exp_q_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
